result_packer: RTL and testbench

Parametrised write-back stage for the matrix/vector accelerator. It takes the stream of signed accumulator results (one per output row M) and applies the arithmetic right shift `a` and the activation function. It narrows each result to an 8- or 16-bit element, packs k' elements per memory word, and issues store requests on the ExtMem request interface. It replaces the fixed 8-lane store path with a configurable word width, element width and lane count.

---
 rtl/result_packer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_result_packer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_packer.sv
// -----------------------------------------------------------------------------
// result_packer
//
// Write-back stage for the matrix/vector accelerator. Each signed accumulator
// result is arithmetically shifted right, optionally passed through ReLU,
// narrowed to an 8- or 16-bit element and packed LSB-lane-first into a memory
// word. When k elements have been collected (or the last of M results has
// arrived) the word is issued as a store request on the ExtMem interface.
//
// Optional build feature:
//   RESULT_PACKER_SAT_EN  - when defined, narrowing saturates to the element
//                           range instead of truncating to the low EW bits.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   cfg_*                 job configuration (valid/ready, accepted in IDLE)
//   acc_*                 accumulator result stream (valid/ready)
//   mem_req_*             store request (valid/ready, addr, cmd, typ, data)
//   done_o                one-cycle pulse after the last word is stored
// -----------------------------------------------------------------------------
module result_packer #(
  parameter int ACC_W  = 64,
  parameter int WORD_W = 64,
  parameter int ADDR_W = 40,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic              cfg_bitwidth_i,
  input  logic [1:0]        cfg_actfun_i,
  input  logic [5:0]        cfg_shift_i,
  input  logic [3:0]        cfg_k_i,
  input  logic [CNT_W-1:0]  cfg_count_i,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic              acc_valid_i,
  output logic              acc_ready_o,
  input  logic [ACC_W-1:0]  acc_data_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [4:0]        mem_req_cmd_o,
  output logic [2:0]        mem_req_typ_o,
  output logic [WORD_W-1:0] mem_req_data_o,
  output logic              done_o
);

  // Lane bookkeeping: the lane counter must hold the full 8-bit lane count
  // and also any 4-bit k value, whichever is wider.
  localparam int LANES8   = WORD_W / 8;
  localparam int LANES16  = WORD_W / 16;
  localparam int LANE_RAW = $clog2(LANES8 + 1);
  localparam int LANE_W   = (LANE_RAW > 4) ? LANE_RAW : 4;
  localparam int POS_W    = LANE_W + 4;

  localparam logic [LANE_W-1:0] C_LANES8    = LANE_W'(LANES8);
  localparam logic [LANE_W-1:0] C_LANES16   = LANE_W'(LANES16);
  localparam logic [LANE_W-1:0] C_LANE_ZERO = {LANE_W{1'b0}};
  localparam logic [LANE_W-1:0] C_LANE_ONE  = LANE_W'(1);
  localparam logic [CNT_W-1:0]  C_CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] C_ADDR_STEP = ADDR_W'(WORD_W / 8);
  localparam logic signed [ACC_W-1:0] C_ZERO = {ACC_W{1'b0}};
`ifdef RESULT_PACKER_SAT_EN
  localparam logic signed [ACC_W-1:0] C_MAX8  = ACC_W'(32'sd127);
  localparam logic signed [ACC_W-1:0] C_MIN8  = ACC_W'(-32'sd128);
  localparam logic signed [ACC_W-1:0] C_MAX16 = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] C_MIN16 = ACC_W'(-32'sd32768);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Narrow a shifted accumulator value to one element. The result is always
  // returned in 16 bits; for 8-bit elements the upper byte is zero so the
  // element can be OR-ed straight into its lane.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] f_narrow(
    input logic signed [ACC_W-1:0] v,
    input logic                    bw16,
    input logic                    relu
  );
    logic [15:0] res;
`ifdef RESULT_PACKER_SAT_EN
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = bw16 ? C_MAX16 : C_MAX8;
    if (relu) begin
      lo = C_ZERO;
    end else if (bw16) begin
      lo = C_MIN16;
    end else begin
      lo = C_MIN8;
    end
    if (v > hi) begin
      res = hi[15:0];
    end else if (v < lo) begin
      res = lo[15:0];
    end else begin
      res = v[15:0];
    end
`else
    if (relu && (v < C_ZERO)) begin
      res = 16'h0000;
    end else begin
      res = v[15:0];
    end
`endif
    return bw16 ? res : {8'h00, res[7:0]};
  endfunction

  // Registers
  state_t              r_state;
  logic                r_bw;
  logic                r_relu;
  logic [5:0]          r_shift;
  logic [LANE_W-1:0]   r_k;
  logic [CNT_W-1:0]    r_m;
  logic [CNT_W-1:0]    r_cnt;
  logic [LANE_W-1:0]   r_lane;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_buf;
  logic                r_cfg_ready;
  logic                r_acc_ready;
  logic                r_mem_valid;
  logic                r_done;

  // Combinational helpers
  logic [LANE_W-1:0]       w_k_cfg;
  logic [LANE_W-1:0]       w_lanes_cfg;
  logic [LANE_W-1:0]       w_k_eff;
  logic signed [ACC_W-1:0] w_v;
  logic [15:0]             w_elem;
  logic [POS_W-1:0]        w_pos;
  logic [WORD_W-1:0]       w_elem_word;
  logic [LANE_W-1:0]       w_lane_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_word_end;
  logic                    w_cfg_fire;
  logic                    w_acc_fire;
  logic                    w_mem_fire;

  // Effective elements-per-word: 0 or an over-large k means "fill the word".
  always_comb begin
    w_k_cfg     = LANE_W'(cfg_k_i);
    w_lanes_cfg = cfg_bitwidth_i ? C_LANES16 : C_LANES8;
    if ((w_k_cfg == C_LANE_ZERO) || (w_k_cfg > w_lanes_cfg)) begin
      w_k_eff = w_lanes_cfg;
    end else begin
      w_k_eff = w_k_cfg;
    end
  end

  // Element datapath: shift, activation/narrowing, and placement in its lane.
  always_comb begin
    w_v         = $signed(acc_data_i) >>> r_shift;
    w_elem      = f_narrow(w_v, r_bw, r_relu);
    // Lane bit offset is lane*16 or lane*8.
    w_pos       = r_bw ? {r_lane, 4'b0000} : {1'b0, r_lane, 3'b000};
    w_elem_word = WORD_W'(w_elem) << w_pos;
  end

  // Handshakes and end-of-word detection.
  always_comb begin
    w_cfg_fire = cfg_valid_i && r_cfg_ready;
    w_acc_fire = acc_valid_i && r_acc_ready;
    w_mem_fire = r_mem_valid && mem_req_ready_i;
    w_lane_nxt = r_lane + C_LANE_ONE;
    w_cnt_nxt  = r_cnt + C_CNT_ONE;
    w_word_end = (w_lane_nxt == r_k) || (w_cnt_nxt == r_m);
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_bw        <= 1'b0;
      r_relu      <= 1'b0;
      r_shift     <= 6'd0;
      r_k         <= C_LANE_ZERO;
      r_m         <= C_CNT_ZERO;
      r_cnt       <= C_CNT_ZERO;
      r_lane      <= C_LANE_ZERO;
      r_addr      <= {ADDR_W{1'b0}};
      r_buf       <= {WORD_W{1'b0}};
      r_cfg_ready <= 1'b1;
      r_acc_ready <= 1'b0;
      r_mem_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cfg_fire) begin
            r_bw        <= cfg_bitwidth_i;
            r_relu      <= (cfg_actfun_i == 2'd1);
            r_shift     <= cfg_shift_i;
            r_k         <= w_k_eff;
            r_m         <= cfg_count_i;
            r_addr      <= cfg_addr_i;
            r_cnt       <= C_CNT_ZERO;
            r_lane      <= C_LANE_ZERO;
            r_buf       <= {WORD_W{1'b0}};
            r_cfg_ready <= 1'b0;
            if (cfg_count_i == C_CNT_ZERO) begin
              // Empty job: report completion without touching memory.
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_RUN;
              r_acc_ready <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_acc_fire) begin
            r_buf  <= r_buf | w_elem_word;
            r_lane <= w_lane_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_word_end) begin
              r_state     <= S_WRITE;
              r_acc_ready <= 1'b0;
              r_mem_valid <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          // Address and data stay put until the store is accepted.
          if (w_mem_fire) begin
            r_mem_valid <= 1'b0;
            r_addr      <= r_addr + C_ADDR_STEP;
            r_buf       <= {WORD_W{1'b0}};
            r_lane      <= C_LANE_ZERO;
            if (r_cnt == r_m) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_RUN;
              r_acc_ready <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_done      <= 1'b0;
          r_cfg_ready <= 1'b1;
        end
        default: begin
          // Unreachable encoding: fall back to a clean idle state.
          r_state     <= S_IDLE;
          r_cfg_ready <= 1'b1;
          r_acc_ready <= 1'b0;
          r_mem_valid <= 1'b0;
          r_done      <= 1'b0;
          r_buf       <= {WORD_W{1'b0}};
          r_lane      <= C_LANE_ZERO;
        end
      endcase
    end
  end

  assign cfg_ready_o     = r_cfg_ready;
  assign acc_ready_o     = r_acc_ready;
  assign mem_req_valid_o = r_mem_valid;
  assign mem_req_addr_o  = r_addr;
  assign mem_req_data_o  = r_buf;
  assign mem_req_cmd_o   = 5'h01;
  assign mem_req_typ_o   = 3'b011;
  assign done_o          = r_done;

endmodule

// File: tb/tb_result_packer.sv
module tb_result_packer;
  logic        clk;
  logic        reset;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic        cfg_bitwidth_i;
  logic [1:0]  cfg_actfun_i;
  logic [5:0]  cfg_shift_i;
  logic [3:0]  cfg_k_i;
  logic [6:0]  cfg_count_i;
  logic [39:0] cfg_addr_i;
  logic        acc_valid_i;
  logic        acc_ready_o;
  logic [63:0] acc_data_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [39:0] mem_req_addr_o;
  logic [4:0]  mem_req_cmd_o;
  logic [2:0]  mem_req_typ_o;
  logic [63:0] mem_req_data_o;
  logic        done_o;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] acc_q[$];
  logic [63:0] got_data[$];
  logic [39:0] got_addr[$];

  result_packer dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_valid_i     (cfg_valid_i),
    .cfg_ready_o     (cfg_ready_o),
    .cfg_bitwidth_i  (cfg_bitwidth_i),
    .cfg_actfun_i    (cfg_actfun_i),
    .cfg_shift_i     (cfg_shift_i),
    .cfg_k_i         (cfg_k_i),
    .cfg_count_i     (cfg_count_i),
    .cfg_addr_i      (cfg_addr_i),
    .acc_valid_i     (acc_valid_i),
    .acc_ready_o     (acc_ready_o),
    .acc_data_i      (acc_data_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_cmd_o   (mem_req_cmd_o),
    .mem_req_typ_o   (mem_req_typ_o),
    .mem_req_data_o  (mem_req_data_o),
    .done_o          (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference element: value >>> a, then ReLU / saturation / truncation.
  function automatic logic [15:0] model_elem(logic [63:0] acc, int bw, int act, int sh);
    longint v;
    longint hi;
    longint lo;
    logic [63:0] u;
    int ew;
    ew = (bw != 0) ? 16 : 8;
    v  = longint'(acc) >>> sh;
`ifdef RESULT_PACKER_SAT_EN
    hi = (longint'(1) <<< (ew - 1)) - 1;
    lo = (act == 1) ? longint'(0) : -(longint'(1) <<< (ew - 1));
    if (v > hi) v = hi;
    if (v < lo) v = lo;
`else
    if (act == 1 && v < 0) v = 0;
`endif
    u = 64'(v);
    return (bw != 0) ? u[15:0] : {8'h00, u[7:0]};
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cfg_ready"}, 64'(cfg_ready_o), 64'd1);
    chk({tag, "_acc_ready"}, 64'(acc_ready_o), 64'd0);
    chk({tag, "_mem_valid"}, 64'(mem_req_valid_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_addr"}, 64'(mem_req_addr_o), 64'd0);
    chk({tag, "_data"}, mem_req_data_o, 64'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the
  // configuration handshake.
  task automatic start_cfg(input int bw, input int act, input int sh, input int k,
                           input int m, input logic [39:0] addr);
    chk("cfg_ready_idle", 64'(cfg_ready_o), 64'd1);
    cfg_valid_i    = 1'b1;
    cfg_bitwidth_i = 1'(bw);
    cfg_actfun_i   = 2'(act);
    cfg_shift_i    = 6'(sh);
    cfg_k_i        = 4'(k);
    cfg_count_i    = 7'(m);
    cfg_addr_i     = addr;
    @(negedge clk);
    cfg_valid_i = 1'b0;
  endtask

  // rmode: 0 always ready, 1 random ready/valid, 2 ready held low 5 cycles per word
  task automatic run_job(input int bw, input int act, input int sh, input int k,
                         input int m, input logic [39:0] addr, input int rmode);
    logic [63:0] exp_data[$];
    logic [39:0] prev_addr;
    logic [63:0] prev_data;
    int lanes, keff, ew, nexp, idx, nw, extra, cyc, stall;
    bit done_seen, prev_hold;
    lanes = (bw != 0) ? 4 : 8;
    ew    = (bw != 0) ? 16 : 8;
    keff  = (k == 0 || k > lanes) ? lanes : k;
    nexp  = (m + keff - 1) / keff;
    for (int w = 0; w < nexp; w++) exp_data.push_back(64'd0);
    for (int i = 0; i < m; i++)
      exp_data[i / keff] = exp_data[i / keff] |
                           (64'(model_elem(acc_q[i], bw, act, sh)) << ((i % keff) * ew));
    got_data.delete();
    got_addr.delete();
    start_cfg(bw, act, sh, k, m, addr);
    idx = 0; nw = 0; extra = 0; cyc = 0; stall = 0;
    done_seen = 1'b0; prev_hold = 1'b0;
    prev_addr = 40'd0; prev_data = 64'd0;
    while (!done_seen && cyc < 4000) begin
      if (done_o === 1'b1) begin
        done_seen       = 1'b1;
        cfg_valid_i     = 1'b0;
        acc_valid_i     = 1'b0;
        mem_req_ready_i = 1'b0;
      end else begin
        chk("cfg_ready_busy", 64'(cfg_ready_o), 64'd0);
        // Configuration noise while busy must be ignored.
        cfg_valid_i = 1'($urandom_range(1, 0));
        cfg_count_i = 7'($urandom_range(127, 0));
        cfg_k_i     = 4'($urandom_range(15, 0));
        if (idx < m) begin
          acc_valid_i = (rmode == 1) ? ($urandom_range(3, 0) != 0) : 1'b1;
          acc_data_i  = acc_q[idx];
        end else begin
          acc_valid_i = 1'($urandom_range(1, 0));
          acc_data_i  = {$urandom(), $urandom()};
        end
        case (rmode)
          0:       mem_req_ready_i = 1'b1;
          1:       mem_req_ready_i = 1'($urandom_range(1, 0));
          default: mem_req_ready_i = (stall >= 5);
        endcase
        if (acc_valid_i && acc_ready_o) begin
          if (idx < m) idx++;
          else extra++;
        end
        if (mem_req_valid_o) begin
          chk("acc_ready_in_write", 64'(acc_ready_o), 64'd0);
          if (prev_hold) begin
            chk("stall_addr_stable", 64'(mem_req_addr_o), 64'(prev_addr));
            chk("stall_data_stable", mem_req_data_o, prev_data);
          end
          if (mem_req_ready_i) begin
            got_data.push_back(mem_req_data_o);
            got_addr.push_back(mem_req_addr_o);
            chk("store_cmd", 64'(mem_req_cmd_o), 64'h01);
            chk("store_typ", 64'(mem_req_typ_o), 64'h3);
            if (nw < nexp) begin
              chk("store_data", mem_req_data_o, exp_data[nw]);
              chk("store_addr", 64'(mem_req_addr_o), 64'(addr + 40'(nw * 8)));
            end
            nw++;
            stall     = 0;
            prev_hold = 1'b0;
          end else begin
            stall++;
            prev_hold = 1'b1;
            prev_addr = mem_req_addr_o;
            prev_data = mem_req_data_o;
          end
        end else begin
          prev_hold = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("job_done_seen", 64'(done_seen), 64'd1);
    chk("job_word_count", 64'(nw), 64'(nexp));
    chk("job_acc_accepted", 64'(idx), 64'(m));
    chk("job_acc_extra", 64'(extra), 64'd0);
    // done_o is a single-cycle pulse, then the block is idle again.
    chk("done_pulse_end", 64'(done_o), 64'd0);
    chk("idle_after_done", 64'(cfg_ready_o), 64'd1);
  endtask

  initial begin
    int bw, act, sh, k, m, rmode, fed, cyc;
    logic [39:0] addr;
    logic [63:0] v;
    reset = 1'b0;
    cfg_valid_i = 1'b0; cfg_bitwidth_i = 1'b0; cfg_actfun_i = 2'd0; cfg_shift_i = 6'd0;
    cfg_k_i = 4'd0; cfg_count_i = 7'd0; cfg_addr_i = 40'd0;
    acc_valid_i = 1'b0; acc_data_i = 64'd0; mem_req_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single element, single store.
    acc_q.delete(); acc_q.push_back(64'h5);
    run_job(0, 0, 0, 1, 1, 40'h10, 0);
    chk("t1_nwords", 64'(got_data.size()), 64'd1);
    chk("t1_data", got_data[0], 64'h05);
    chk("t1_addr", 64'(got_addr[0]), 64'h10);

    // Full 8-lane pack, M=10 -> two words.
    acc_q.delete();
    for (int i = 1; i <= 10; i++) acc_q.push_back(64'(i));
    run_job(0, 0, 0, 0, 10, 40'h100, 0);
    chk("t2_nwords", 64'(got_data.size()), 64'd2);
    chk("t2_w0", got_data[0], 64'h0807060504030201);
    chk("t2_w1", got_data[1], 64'h0A09);
    chk("t2_a1", 64'(got_addr[1]), 64'h108);

    // 16-bit, ReLU, shift 4, k=3.
    acc_q.delete();
    acc_q.push_back(64'h120); acc_q.push_back(-64'sh40);
    acc_q.push_back(64'h7FF0); acc_q.push_back(64'h10);
    run_job(1, 1, 4, 3, 4, 40'h2000, 0);
    chk("t3_w0", got_data[0], 64'h0000_07FF_0000_0012);
    chk("t3_w1", got_data[1], 64'h0001);

    // Store stalled 5 cycles per word.
    acc_q.delete();
    for (int i = 0; i < 6; i++) acc_q.push_back({$urandom(), $urandom()});
    run_job(1, 0, 3, 2, 6, 40'h40, 2);

    // Empty job: done without any store.
    acc_q.delete();
    run_job(0, 0, 0, 0, 0, 40'h80, 0);
    chk("t_empty_nwords", 64'(got_data.size()), 64'd0);

    // Out-of-range values: saturation or truncation depending on the build.
    acc_q.delete(); acc_q.push_back(64'd300); acc_q.push_back(-64'sd300);
    run_job(0, 0, 0, 0, 2, 40'h300, 0);
`ifdef RESULT_PACKER_SAT_EN
    chk("t_sat_w0", got_data[0], 64'h807F);
`else
    chk("t_trunc_w0", got_data[0], 64'hD42C);
`endif

    // Asynchronous reset in the middle of a job (after 3 of 8 results).
    start_cfg(0, 0, 0, 0, 8, 40'h500);
    fed = 0; cyc = 0;
    while (fed < 3 && cyc < 100) begin
      acc_valid_i = 1'b1;
      acc_data_i  = 64'(fed + 17);
      if (acc_ready_o) fed++;
      @(negedge clk);
      cyc++;
    end
    acc_valid_i = 1'b0;
    chk("mid_reset_fed", 64'(fed), 64'd3);
    #2 reset = 1'b0;
    #1 check_reset_vals("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    acc_q.delete();
    for (int i = 0; i < 5; i++) acc_q.push_back(64'(i * 3 + 1));
    run_job(0, 1, 0, 4, 5, 40'h600, 0);
    chk("post_reset_w0", got_data[0], 64'h0A07_0401);
    chk("post_reset_w1", got_data[1], 64'h0D);

    // Maximum count, full 16-bit pack.
    acc_q.delete();
    for (int i = 0; i < 127; i++) acc_q.push_back({$urandom(), $urandom()});
    run_job(1, 0, 0, 0, 127, 40'hFF_FFFF_FF00, 1);

    // Randomised jobs.
    for (int j = 0; j < 24; j++) begin
      bw    = int'($urandom_range(1, 0));
      act   = int'($urandom_range(3, 0));
      sh    = ($urandom_range(3, 0) == 0) ? int'($urandom_range(63, 0)) : int'($urandom_range(8, 0));
      k     = int'($urandom_range(15, 0));
      m     = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(40, 1));
      rmode = int'($urandom_range(2, 0));
      addr  = 40'({$urandom(), $urandom()});
      addr[2:0] = 3'b000;
      acc_q.delete();
      for (int i = 0; i < m; i++) begin
        if ($urandom_range(1, 0) == 0) v = {$urandom(), $urandom()};
        else v = 64'(longint'($urandom_range(80000, 0)) - longint'(40000));
        acc_q.push_back(v);
      end
      run_job(bw, act, sh, k, m, addr, rmode);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
